// File: rtl/mem_access_bridge.sv
// Memory-stage bridge: M-stage load/store to split-handshake data-SRAM bus.
// Optional bus watchdog enabled by defining MEMB_TIMEOUT_EN.
module mem_access_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  op_i,
   input  logic        valid_i,
   input  logic        flush_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        adel_o,
   output logic        ades_o,
   output logic        stall_o,
   output logic        data_req,
   output logic        data_wr,
   output logic [1:0]  data_size,
   output logic [31:0] data_addr,
   output logic [3:0]  data_be,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        bus_err_o
);

   localparam logic [5:0] OpLb  = 6'b100000;
   localparam logic [5:0] OpLh  = 6'b100001;
   localparam logic [5:0] OpLw  = 6'b100011;
   localparam logic [5:0] OpLbu = 6'b100100;
   localparam logic [5:0] OpLhu = 6'b100101;
   localparam logic [5:0] OpSb  = 6'b101000;
   localparam logic [5:0] OpSh  = 6'b101001;
   localparam logic [5:0] OpSw  = 6'b101011;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StReq   = 3'd1;
   localparam logic [2:0] StWait  = 3'd2;
   localparam logic [2:0] StDone  = 3'd3;
   localparam logic [2:0] StDrain = 3'd4;

   logic [2:0]  stateQ, stateD;
   logic [31:0] dataQ, dataD;
   logic        isLoad, isStore, misaligned, access, timeout;
   logic [1:0]  sizeSel;
   logic [3:0]  beSel;
   logic [31:0] wdataSel;
   logic        reqComb, stallComb;
   logic [7:0]  byteVal;
   logic [15:0] halfVal;

   always_comb begin
      isLoad  = 1'b0;
      isStore = 1'b0;
      sizeSel = 2'd0;
      case (op_i)
         OpLb, OpLbu: begin isLoad = 1'b1;  sizeSel = 2'd0; end
         OpLh, OpLhu: begin isLoad = 1'b1;  sizeSel = 2'd1; end
         OpLw:        begin isLoad = 1'b1;  sizeSel = 2'd2; end
         OpSb:        begin isStore = 1'b1; sizeSel = 2'd0; end
         OpSh:        begin isStore = 1'b1; sizeSel = 2'd1; end
         OpSw:        begin isStore = 1'b1; sizeSel = 2'd2; end
         default:     ;
      endcase
   end

   assign misaligned = ((sizeSel == 2'd1) & addr_i[0]) |
                       ((sizeSel == 2'd2) & (addr_i[1:0] != 2'b00));
   assign access = valid_i & (isLoad | isStore) & ~misaligned & ~flush_i;

   always_comb begin
      beSel    = 4'b1111;
      wdataSel = wdata_i;
      case (sizeSel)
         2'd0: begin
            beSel    = 4'b0001 << addr_i[1:0];
            wdataSel = {4{wdata_i[7:0]}};
         end
         2'd1: begin
            beSel    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdataSel = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef MEMB_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT_CYCLES >= 256) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CntW-1:0] cntQ;
   logic            counting;

   assign counting = (stateQ == StReq) | (stateQ == StWait) | (stateQ == StDrain);
   assign timeout  = counting & (cntQ == CntW'(TIMEOUT_CYCLES));

   // Restarts on every state change so each phase gets its own budget.
   always_ff @(posedge clk) begin
      if (rst) begin
         cntQ <= '0;
      end else if (stateD != stateQ) begin
         cntQ <= '0;
      end else if (counting) begin
         cntQ <= cntQ + 1'b1;
      end
   end

   assign bus_err_o = timeout & ~rst;
`else
   assign timeout   = 1'b0;
   assign bus_err_o = 1'b0;
`endif

   always_comb begin
      stateD    = stateQ;
      dataD     = dataQ;
      reqComb   = 1'b0;
      stallComb = 1'b0;
      case (stateQ)
         StIdle: begin
            reqComb   = access;
            stallComb = access;
            if (access) stateD = data_addr_ok ? StWait : StReq;
         end
         StReq: begin
            reqComb   = 1'b1;
            stallComb = 1'b1;
            // Accepted on the same edge as a flush: the response must still be drained.
            if (data_addr_ok)  stateD = flush_i ? StDrain : StWait;
            else if (flush_i) stateD = StIdle;
         end
         StWait: begin
            stallComb = ~flush_i;
            if (flush_i) begin
               stateD = data_data_ok ? StIdle : StDrain;
            end else if (data_data_ok) begin
               stateD = StDone;
               dataD  = data_rdata;
            end
         end
         StDone: stateD = StIdle;
         StDrain: begin
            stallComb = access;
            if (data_data_ok) stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase
      if (timeout) begin
         stateD    = StIdle;
         reqComb   = 1'b0;
         stallComb = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= StIdle;
         dataQ  <= '0;
      end else begin
         stateQ <= stateD;
         dataQ  <= dataD;
      end
   end

   assign byteVal = dataQ[{addr_i[1:0], 3'b000} +: 8];
   assign halfVal = addr_i[1] ? dataQ[31:16] : dataQ[15:0];

   always_comb begin
      rdata_o = '0;
      if (!rst && stateQ == StDone) begin
         case (op_i)
            OpLb:    rdata_o = {{24{byteVal[7]}}, byteVal};
            OpLbu:   rdata_o = {24'h0, byteVal};
            OpLh:    rdata_o = {{16{halfVal[15]}}, halfVal};
            OpLhu:   rdata_o = {16'h0, halfVal};
            OpLw:    rdata_o = dataQ;
            default: rdata_o = '0;
         endcase
      end
   end

   assign adel_o     = ~rst & valid_i & isLoad & misaligned;
   assign ades_o     = ~rst & valid_i & isStore & misaligned;
   assign stall_o    = ~rst & stallComb;
   assign data_req   = ~rst & reqComb;
   assign data_wr    = ~rst & access & isStore;
   assign data_size  = (~rst & access) ? sizeSel : 2'd0;
   assign data_addr  = (~rst & access) ? addr_i : 32'h0;
   assign data_be    = (~rst & access) ? beSel : 4'h0;
   assign data_wdata = (~rst & access & isStore) ? wdataSel : 32'h0;

endmodule

// File: tb/tb_mem_access_bridge.sv
// Self-checking bench for mem_access_bridge; load results checked through a scoreboard.
module tb_mem_access_bridge;

   localparam logic [5:0] OpLb  = 6'b100000;
   localparam logic [5:0] OpLh  = 6'b100001;
   localparam logic [5:0] OpLw  = 6'b100011;
   localparam logic [5:0] OpLbu = 6'b100100;
   localparam logic [5:0] OpLhu = 6'b100101;
   localparam logic [5:0] OpSb  = 6'b101000;
   localparam logic [5:0] OpSh  = 6'b101001;
   localparam logic [5:0] OpSw  = 6'b101011;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op_i;
   logic        valid_i, flush_i;
   logic [31:0] addr_i, wdata_i, rdata_o;
   logic        adel_o, ades_o, stall_o;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_be;
   logic        data_addr_ok, data_data_ok, bus_err_o;

   int nChecks = 0;
   int nFails  = 0;
   logic [31:0] sbQ[$];
   logic prevStall = 1'b0;

   always #5 clk = ~clk;

   mem_access_bridge #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .op_i(op_i), .valid_i(valid_i), .flush_i(flush_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .adel_o(adel_o),
      .ades_o(ades_o), .stall_o(stall_o), .data_req(data_req), .data_wr(data_wr),
      .data_size(data_size), .data_addr(data_addr), .data_be(data_be),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata), .bus_err_o(bus_err_o)
   );

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit isLoadOp(input logic [5:0] op);
      return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
   endfunction

   // A load retires when the stall drops after having been high, without flush/error.
   always @(negedge clk) begin
      if (!rst && !flush_i && !bus_err_o && valid_i && isLoadOp(op_i) && !stall_o && prevStall)
      begin
         checkEq("sb_pending", 32'(sbQ.size() != 0), 32'd1);
         if (sbQ.size() != 0) checkEq("rdata", rdata_o, sbQ.pop_front());
      end
      prevStall = stall_o;
   end

   typedef struct {
      logic [5:0]  op;
      logic [31:0] addr, wdata, rword;
      int          aDly, dDly;
      logic [3:0]  be;
      logic [1:0]  size;
      logic        wr;
      logic [31:0] wd, rexp;
      int          stalls;
   } case_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic runCase(input case_t c);
      int aCnt = 0, dCnt = 0, phase = 0, nStall = 0, nReq = 0;
      bit done = 1'b0;
      op_i = c.op; addr_i = c.addr; wdata_i = c.wdata; valid_i = 1'b1; flush_i = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         data_addr_ok = (phase == 0) && (aCnt == c.aDly);
         data_data_ok = (phase == 1) && (dCnt == c.dDly);
         data_rdata   = data_data_ok ? c.rword : 32'h0;
         if (data_data_ok && isLoadOp(c.op)) sbQ.push_back(c.rexp);
         #1;
         if (stall_o) nStall++;
         if (data_req) nReq++;
         if (cyc == 0) begin
            checkEq("be", 32'(data_be), 32'(c.be));
            checkEq("size", 32'(data_size), 32'(c.size));
            checkEq("wr", 32'(data_wr), 32'(c.wr));
            checkEq("addr", data_addr, c.addr);
            if (c.wr) checkEq("wdata", data_wdata, c.wd);
         end
         if (phase == 2) begin
            checkEq("done_stall", 32'(stall_o), 32'd0);
            checkEq("done_req", 32'(data_req), 32'd0);
            done = 1'b1;
         end else begin
            checkEq("rdata_notdone", rdata_o, 32'h0);
            if (phase == 1) begin
               if (data_data_ok) phase = 2; else dCnt++;
            end else begin
               if (data_addr_ok) phase = 1; else aCnt++;
            end
         end
         tick();
      end
      checkEq("finished", 32'(done), 32'd1);
      checkEq("stall_cycles", 32'(nStall), 32'(c.stalls));
      checkEq("req_cycles", 32'(nReq), 32'(c.aDly + 1));
      valid_i = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      tick();
   endtask

   task automatic misalign(input logic [5:0] op, input logic [31:0] addr,
                           input logic expAdel, input logic expAdes);
      op_i = op; addr_i = addr; valid_i = 1'b1; data_addr_ok = 1'b1;
      #1;
      checkEq("adel", 32'(adel_o), 32'(expAdel));
      checkEq("ades", 32'(ades_o), 32'(expAdes));
      checkEq("mis_req", 32'(data_req), 32'd0);
      checkEq("mis_stall", 32'(stall_o), 32'd0);
      tick();
      valid_i = 1'b0; data_addr_ok = 1'b0;
      #1;
      checkEq("mis_after_stall", 32'(stall_o), 32'd0);
      tick();
   endtask

   case_t cases[9];

   initial begin
      cases[0] = '{OpLb,  32'h1003, 32'h0,        32'h80FF_0000, 0, 0, 4'b1000, 2'd0, 1'b0,
                   32'h0, 32'hFFFF_FF80, 2};
      cases[1] = '{OpSh,  32'h2002, 32'h0000_ABCD, 32'hDEAD_BEEF, 3, 0, 4'b1100, 2'd1, 1'b1,
                   32'hABCD_ABCD, 32'h0, 5};
      cases[2] = '{OpLbu, 32'h3001, 32'h0,        32'h1234_5678, 1, 2, 4'b0010, 2'd0, 1'b0,
                   32'h0, 32'h0000_0056, 5};
      cases[3] = '{OpLh,  32'h4002, 32'h0,        32'h8001_7FFF, 0, 0, 4'b1100, 2'd1, 1'b0,
                   32'h0, 32'hFFFF_8001, 2};
      cases[4] = '{OpLhu, 32'h4000, 32'h0,        32'h8001_FFFE, 0, 1, 4'b0011, 2'd1, 1'b0,
                   32'h0, 32'h0000_FFFE, 3};
      cases[5] = '{OpLw,  32'h5004, 32'h0,        32'hCAFE_F00D, 0, 0, 4'b1111, 2'd2, 1'b0,
                   32'h0, 32'hCAFE_F00D, 2};
      cases[6] = '{OpSb,  32'h6001, 32'h1234_56A5, 32'h0,        0, 0, 4'b0010, 2'd0, 1'b1,
                   32'hA5A5_A5A5, 32'h0, 2};
      cases[7] = '{OpSw,  32'h6008, 32'h89AB_CDEF, 32'h0,        2, 0, 4'b1111, 2'd2, 1'b1,
                   32'h89AB_CDEF, 32'h0, 4};
      cases[8] = '{OpLb,  32'h1000, 32'h0,        32'hFFFF_FF7F, 0, 0, 4'b0001, 2'd0, 1'b0,
                   32'h0, 32'h0000_007F, 2};

      rst = 1'b1; op_i = 6'h0; valid_i = 1'b0; flush_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
      tick(); tick();
      checkEq("rst_stall", 32'(stall_o), 32'd0);
      checkEq("rst_req", 32'(data_req), 32'd0);
      checkEq("rst_rdata", rdata_o, 32'h0);
      checkEq("rst_buserr", 32'(bus_err_o), 32'd0);
      rst = 1'b0;
      tick();

      foreach (cases[i]) runCase(cases[i]);

      misalign(OpLw, 32'h1001, 1'b1, 1'b0);
      misalign(OpSw, 32'h1002, 1'b0, 1'b1);
      misalign(OpLh, 32'h1001, 1'b1, 1'b0);
      misalign(OpSh, 32'h1003, 1'b0, 1'b1);
      misalign(6'b000000, 32'h1003, 1'b0, 1'b0);

      // Flush while waiting on an LHU, then a new LW arrives during the drain.
      op_i = OpLhu; addr_i = 32'h7002; valid_i = 1'b1; data_addr_ok = 1'b1;
      #1; checkEq("fl_req", 32'(data_req), 32'd1);
      tick();
      data_addr_ok = 1'b0; flush_i = 1'b1;
      #1; checkEq("fl_wait_stall", 32'(stall_o), 32'd0);
      tick();
      flush_i = 1'b0; op_i = OpLw; addr_i = 32'h8000; data_addr_ok = 1'b1;
      #1;
      checkEq("drain_stall", 32'(stall_o), 32'd1);
      checkEq("drain_req", 32'(data_req), 32'd0);
      tick();
      data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
      #1;
      checkEq("drain_stall2", 32'(stall_o), 32'd1);
      checkEq("drain_req2", 32'(data_req), 32'd0);
      tick();
      data_data_ok = 1'b0; data_rdata = 32'h0;
      #1;
      checkEq("new_req", 32'(data_req), 32'd1);
      checkEq("new_be", 32'(data_be), 32'hF);
      tick();
      data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1122_3344;
      sbQ.push_back(32'h1122_3344);
      #1; checkEq("new_wait_req", 32'(data_req), 32'd0);
      tick();
      data_data_ok = 1'b0; data_rdata = 32'h0;
      #1; checkEq("new_done_stall", 32'(stall_o), 32'd0);
      tick();
      valid_i = 1'b0;
      tick();

      // Reset while the request is still pending.
      op_i = OpLw; addr_i = 32'h9000; valid_i = 1'b1;
      tick();
      #1; checkEq("req_held", 32'(data_req), 32'd1);
      rst = 1'b1; valid_i = 1'b0;
      tick();
      rst = 1'b0;
      #1;
      checkEq("post_rst_req", 32'(data_req), 32'd0);
      checkEq("post_rst_stall", 32'(stall_o), 32'd0);
      data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
      tick();
      data_data_ok = 1'b0;
      #1;
      checkEq("stray_rdata", rdata_o, 32'h0);
      checkEq("stray_stall", 32'(stall_o), 32'd0);
      tick();

`ifdef MEMB_TIMEOUT_EN
      op_i = OpLw; addr_i = 32'hA000; valid_i = 1'b1; data_addr_ok = 1'b1;
      tick();
      data_addr_ok = 1'b0;
      for (int w = 0; w < 5; w++) begin
         #1;
         checkEq("to_err", 32'(bus_err_o), (w == 4) ? 32'd1 : 32'd0);
         checkEq("to_stall", 32'(stall_o), (w == 4) ? 32'd0 : 32'd1);
         tick();
      end
      valid_i = 1'b0;
      #1;
      checkEq("to_after_err", 32'(bus_err_o), 32'd0);
      checkEq("to_after_stall", 32'(stall_o), 32'd0);
      tick();
`endif

      checkEq("sb_empty", 32'(sbQ.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
